rv_hazard: RTL and testbench
============================

RV_HAZARD -- requirements
Module: rv_hazard

Interface
REQ-001 SHALL provide parameter FLUSH_CYCLES, default 2, number of cycles the front end is flushed after a redirect (legal 1..7).
REQ-002 SHALL provide port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port i_reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL provide i_dec_valid, input, 1, decode stage presents a valid instruction.
REQ-005 SHALL provide i_dec_rs1 / i_dec_rs2, input, 5 each, source register indices of the decode instruction.
REQ-006 SHALL provide i_dec_rd, input, 5, destination register of the decode instruction.
REQ-007 SHALL provide i_dec_reg_write, input, 1, decode instruction writes rd.
REQ-008 SHALL provide i_dec_load, input, 1, decode instruction's result comes from memory (res_src memory).
REQ-009 SHALL provide i_pc_change, input, 1, taken branch/jal/jalr resolved in alu2 this cycle.
REQ-010 SHALL provide o_stall, output, 1, hold fetch and decode registers.
REQ-011 SHALL provide o_flush, output, 1, kill fetch/decode contents and inject a bubble into alu1.
REQ-012 SHALL provide o_fwd_rs1 / o_fwd_rs2, output, 2 each, operand source for the instruction in alu1: 00 register file, 01 alu2 result, 10 write-stage result, 11 unused.

Function
REQ-013 SHALL keep a 3-entry tracker (alu1, alu2, write), each entry {valid, rd, reg_write, load}.
REQ-014 SHALL advance every cycle: write<=alu2, alu2<=alu1, alu1<=decode entry, or a bubble (valid=0) when o_stall or o_flush is high or i_dec_valid is low.
REQ-015 SHALL treat a source as matching an entry only if the entry is valid, has reg_write=1, rd equals the source, and the source is nonzero; x0 never matches.
REQ-016 SHALL assert o_stall combinationally when i_dec_valid and either source matches the alu1 entry with load=1 (load-use); the stall lasts exactly 1 cycle per hazard.
REQ-017 SHALL compute forward selects in decode and register them with the alu1 entry, so o_fwd_* is valid in the cycle the instruction is in alu1 (1-cycle latency).
REQ-018 SHALL select 01 if the source matches the alu1 entry (next cycle in alu2), else 10 if it matches the alu2 entry (next cycle in write), else 00; the youngest producer wins.
REQ-019 SHALL register o_fwd_*=00 whenever a bubble enters alu1.
REQ-020 SHALL load a 3-bit flush counter with FLUSH_CYCLES-1 on i_pc_change, and assert o_flush in the i_pc_change cycle and while the counter is nonzero; the counter decrements each cycle.
REQ-021 SHALL invalidate the alu1 entry on i_pc_change, since it is the wrong-path instruction behind the redirecting one; alu2 and write entries are unaffected.
REQ-022 SHALL give o_flush priority over o_stall: o_stall=0 while o_flush=1.
REQ-023 SHALL reload the counter when i_pc_change occurs while a flush is in progress (restart window, no accumulation).
REQ-024 SHALL keep all outputs glitch-free functions of registered state plus the listed inputs only; there is no combinational path from o_* back to inputs.

Reset
REQ-025 SHALL, while i_reset=1, clear all tracker valid bits, the flush counter and the registered fwd selects; reset takes priority over every other event.
REQ-026 SHALL drive, during reset and in the first cycle after it, o_stall=0, o_flush=0, o_fwd_rs1=00 and o_fwd_rs2=00.
REQ-027 SHALL discard any stall or flush in progress when reset is asserted mid-operation; no residual flush cycles follow reset.

Verification
REQ-028 Back-to-back ALU ops: add x5 then add x6,x5,x1 -> no stall; second op in alu1 sees o_fwd_rs1=01, o_fwd_rs2=00.
REQ-029 Load-use: lw x7 then add x8,x7,x7 -> o_stall=1 for one cycle; add then enters alu1 with o_fwd_rs1=o_fwd_rs2=10.
REQ-030 x0 destination: add x0 then add x9,x0,x0 -> o_fwd_*=00, no stall.
REQ-031 Redirect with FLUSH_CYCLES=2: i_pc_change pulse -> o_flush high exactly 2 cycles; the alu1 entry is invalidated, with no forward from it afterwards.
REQ-032 Simultaneous load-use and i_pc_change -> o_flush=1, o_stall=0; a second i_pc_change in the flush window extends o_flush to 2 cycles after it.
REQ-033 Reset during flush window -> o_flush=0 the cycle after reset is asserted, and stays 0 after release.

Source files
------------

// File: rtl/rv_hazard.sv
// Hazard unit for a five-stage RISC-V pipeline. It tracks the three
// instructions ahead of decode (alu1, alu2, write) and produces the
// load-use stall, the post-redirect front-end flush and the operand
// forward selects for the instruction in alu1.
//
// Handshake note: there is no valid/ready pair here. i_dec_valid qualifies
// the decode fields, and o_stall/o_flush are level signals that apply to
// the current cycle. An instruction is issued into alu1 at the rising edge
// only if i_dec_valid=1, o_stall=0 and o_flush=0. Any other cycle issues a
// bubble.
module rv_hazard #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_dec_valid,
  input  logic [4:0] i_dec_rs1,
  input  logic [4:0] i_dec_rs2,
  input  logic [4:0] i_dec_rd,
  input  logic       i_dec_reg_write,
  input  logic       i_dec_load,
  input  logic       i_pc_change,
  output logic       o_stall,
  output logic       o_flush,
  output logic [1:0] o_fwd_rs1,
  output logic [1:0] o_fwd_rs2
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       load;
  } entry_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  entry_t     alu1_q, alu2_q, wb_q;
  logic [1:0] fwd_rs1_q, fwd_rs2_q;
  logic [2:0] flush_cnt_q;

  logic       flush_raw;
  logic       stall_raw;
  logic       issue;
  logic [1:0] fwd_rs1_d, fwd_rs2_d;
  entry_t     dec_entry;

  // The write-stage entry completes the tracker. Forward selects are
  // resolved one stage early, so nothing reads it combinationally.
  logic wb_unused;
  assign wb_unused = ^wb_q;

  // A source hits an entry only for a live, register-writing producer.
  // x0 never hits.
  function automatic logic src_hit(input entry_t e, input logic [4:0] src);
    return e.valid && e.reg_write && (e.rd == src) && (src != 5'd0);
  endfunction

  // Decode-side hazard detection and the forward select for the next alu1 entry.
  always_comb begin
    flush_raw = i_pc_change | (flush_cnt_q != 3'd0);
    stall_raw = i_dec_valid & alu1_q.load &
                (src_hit(alu1_q, i_dec_rs1) | src_hit(alu1_q, i_dec_rs2)) &
                ~flush_raw;
    issue     = i_dec_valid & ~stall_raw & ~flush_raw;

    // The youngest producer wins: alu1 now becomes alu2 next cycle.
    fwd_rs1_d = 2'b00;
    if (src_hit(alu1_q, i_dec_rs1))      fwd_rs1_d = 2'b01;
    else if (src_hit(alu2_q, i_dec_rs1)) fwd_rs1_d = 2'b10;
    fwd_rs2_d = 2'b00;
    if (src_hit(alu1_q, i_dec_rs2))      fwd_rs2_d = 2'b01;
    else if (src_hit(alu2_q, i_dec_rs2)) fwd_rs2_d = 2'b10;

    dec_entry = '{valid: 1'b1, rd: i_dec_rd,
                  reg_write: i_dec_reg_write, load: i_dec_load};
  end

  // The outputs are held quiet for the whole reset cycle.
  always_comb begin
    o_flush   = flush_raw & ~i_reset;
    o_stall   = stall_raw & ~i_reset;
    o_fwd_rs1 = i_reset ? 2'b00 : fwd_rs1_q;
    o_fwd_rs2 = i_reset ? 2'b00 : fwd_rs2_q;
  end

  // Advance the tracker and the flush window. Reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu1_q      <= '0;
      alu2_q      <= '0;
      wb_q        <= '0;
      fwd_rs1_q   <= 2'b00;
      fwd_rs2_q   <= 2'b00;
      flush_cnt_q <= 3'd0;
    end else begin
      wb_q   <= alu2_q;
      alu2_q <= alu1_q;
      // The instruction in alu1 is on the wrong path behind the redirect.
      if (i_pc_change) alu2_q.valid <= 1'b0;
      alu1_q    <= issue ? dec_entry : '0;
      fwd_rs1_q <= issue ? fwd_rs1_d : 2'b00;
      fwd_rs2_q <= issue ? fwd_rs2_d : 2'b00;
      if (i_pc_change)              flush_cnt_q <= FLUSH_RELOAD;
      else if (flush_cnt_q != 3'd0) flush_cnt_q <= flush_cnt_q - 3'd1;
    end
  end

endmodule

// File: tb/tb_rv_hazard.sv
// Bench for rv_hazard: directed pipeline scenarios with literal expectations,
// then randomized traffic checked against an instruction-history model.
module tb_rv_hazard;

  localparam int FC = 2;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_dec_valid = 1'b0;
  logic [4:0] i_dec_rs1 = '0, i_dec_rs2 = '0, i_dec_rd = '0;
  logic       i_dec_reg_write = 1'b0, i_dec_load = 1'b0, i_pc_change = 1'b0;
  logic       o_stall, o_flush;
  logic [1:0] o_fwd_rs1, o_fwd_rs2;

  int n_checks = 0;
  int n_fail   = 0;

  rv_hazard #(.FLUSH_CYCLES(FC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_dec_valid(i_dec_valid),
    .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_dec_rd(i_dec_rd),
    .i_dec_reg_write(i_dec_reg_write), .i_dec_load(i_dec_load),
    .i_pc_change(i_pc_change), .o_stall(o_stall), .o_flush(o_flush),
    .o_fwd_rs1(o_fwd_rs1), .o_fwd_rs2(o_fwd_rs2)
  );

  // Clock and safety timeout
  always #5 i_clk = ~i_clk;
  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t reached, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Driver: present one cycle of inputs on the falling edge, settle, return.
  task automatic drive(input logic rst, input logic pc, input logic v,
                       input logic rw, input logic ld,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    @(negedge i_clk);
    i_reset = rst; i_pc_change = pc; i_dec_valid = v;
    i_dec_reg_write = rw; i_dec_load = ld;
    i_dec_rs1 = s1; i_dec_rs2 = s2; i_dec_rd = d;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    nop();
  endtask

  task automatic test_reset();
    // Reset with busy-looking inputs, including a redirect
    drive(1, 1, 1, 1, 1, 5'd3, 5'd4, 5'd5);
    n_checks++;
    if ({o_stall, o_flush, o_fwd_rs1, o_fwd_rs2} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got stall=%b flush=%b f1=%b f2=%b want all 0",
               o_stall, o_flush, o_fwd_rs1, o_fwd_rs2);
    end
    drive(0, 0, 1, 1, 0, 5'd5, 5'd5, 5'd6);
    n_checks++;
    if ({o_stall, o_flush, o_fwd_rs1, o_fwd_rs2} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_after: got stall=%b flush=%b f1=%b f2=%b want all 0",
               o_stall, o_flush, o_fwd_rs1, o_fwd_rs2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(0, 0, 1, 1, 0, 5'd1, 5'd2, 5'd5);   // add x5,x1,x2
    drive(0, 0, 1, 1, 0, 5'd5, 5'd1, 5'd6);   // add x6,x5,x1
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b want 0", o_stall); end
    nop();
    n_checks++;
    if (o_fwd_rs1 !== 2'b01) begin n_fail++; $display("FAIL b2b_fwd1: got %b want 01", o_fwd_rs1); end
    n_checks++;
    if (o_fwd_rs2 !== 2'b00) begin n_fail++; $display("FAIL b2b_fwd2: got %b want 00", o_fwd_rs2); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 0, 1, 1, 1, 5'd1, 5'd0, 5'd7);   // lw x7
    drive(0, 0, 1, 1, 0, 5'd7, 5'd7, 5'd8);   // add x8,x7,x7
    n_checks++;
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", o_stall); end
    drive(0, 0, 1, 1, 0, 5'd7, 5'd7, 5'd8);   // held add
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %b want 0", o_stall); end
    nop();
    n_checks++;
    if ({o_fwd_rs1, o_fwd_rs2} !== 4'b1010) begin
      n_fail++; $display("FAIL lu_fwd: got %b/%b want 10/10", o_fwd_rs1, o_fwd_rs2);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(0, 0, 1, 1, 1, 5'd1, 5'd0, 5'd0);   // lw x0
    drive(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd9);   // add x9,x0,x0
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", o_stall); end
    nop();
    n_checks++;
    if ({o_fwd_rs1, o_fwd_rs2} !== 4'b0000) begin
      n_fail++; $display("FAIL x0_fwd: got %b/%b want 00/00", o_fwd_rs1, o_fwd_rs2);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(0, 0, 1, 1, 0, 5'd1, 5'd2, 5'd10);  // add x10
    drive(0, 1, 1, 1, 0, 5'd10, 5'd10, 5'd11);
    n_checks++;
    if (o_flush !== 1'b1) begin n_fail++; $display("FAIL rd_flush0: got %b want 1", o_flush); end
    drive(0, 0, 1, 1, 0, 5'd10, 5'd10, 5'd12);
    n_checks++;
    if (o_flush !== 1'b1) begin n_fail++; $display("FAIL rd_flush1: got %b want 1", o_flush); end
    drive(0, 0, 1, 1, 0, 5'd10, 5'd10, 5'd13);
    n_checks++;
    if (o_flush !== 1'b0) begin n_fail++; $display("FAIL rd_flush2: got %b want 0", o_flush); end
    n_checks++;
    if ({o_fwd_rs1, o_fwd_rs2} !== 4'b0000) begin
      n_fail++; $display("FAIL rd_bubble_fwd: got %b/%b want 00/00", o_fwd_rs1, o_fwd_rs2);
    end
    nop();
    n_checks++;
    if ({o_fwd_rs1, o_fwd_rs2} !== 4'b0000) begin
      n_fail++; $display("FAIL rd_killed_fwd: got %b/%b want 00/00", o_fwd_rs1, o_fwd_rs2);
    end
  endtask

  task automatic test_loaduse_redirect();
    do_reset();
    drive(0, 0, 1, 1, 1, 5'd1, 5'd0, 5'd7);   // lw x7
    drive(0, 1, 1, 1, 0, 5'd7, 5'd7, 5'd8);   // load-use with redirect
    n_checks++;
    if ({o_flush, o_stall} !== 2'b10) begin
      n_fail++; $display("FAIL lr_prio: got flush=%b stall=%b want 1/0", o_flush, o_stall);
    end
    drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);   // second redirect in window
    n_checks++;
    if (o_flush !== 1'b1) begin n_fail++; $display("FAIL lr_flush_a: got %b want 1", o_flush); end
    nop();
    n_checks++;
    if (o_flush !== 1'b1) begin n_fail++; $display("FAIL lr_flush_b: got %b want 1", o_flush); end
    nop();
    n_checks++;
    if (o_flush !== 1'b0) begin n_fail++; $display("FAIL lr_flush_end: got %b want 0", o_flush); end
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    n_checks++;
    if (o_flush !== 1'b0) begin n_fail++; $display("FAIL rf_in_reset: got %b want 0", o_flush); end
    nop();
    n_checks++;
    if (o_flush !== 1'b0) begin n_fail++; $display("FAIL rf_after1: got %b want 0", o_flush); end
    nop();
    n_checks++;
    if (o_flush !== 1'b0) begin n_fail++; $display("FAIL rf_after2: got %b want 0", o_flush); end
  endtask

  // Reference model: the last two issue slots (youngest first) and the last
  // cycle number still inside a flush window.
  typedef struct {
    logic       valid;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic [1:0] f1;
    logic [1:0] f2;
  } slot_t;

  function automatic logic hit(input slot_t e, input logic [4:0] s);
    return e.valid && e.rw && (e.rd == s) && (s != 5'd0);
  endfunction

  function automatic logic [1:0] pick(input slot_t y, input slot_t o, input logic [4:0] s);
    if (hit(y, s)) return 2'b01;
    if (hit(o, s)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_random();
    slot_t hist[$];
    slot_t bubble, nw;
    int cyc, flush_until;
    logic rst, pc, v, rw, ld, flushing, e_stall, e_flush, prev_rst;
    logic [4:0] s1, s2, d;
    logic [1:0] e_f1, e_f2;
    bubble = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0, f1: 2'b00, f2: 2'b00};
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    hist = '{bubble, bubble};
    flush_until = -1;
    cyc = 0;
    prev_rst = 1'b1;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      pc  = !prev_rst && ($urandom_range(0, 11) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rw  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 2) == 0);
      s1  = 5'($urandom_range(0, 3));
      s2  = 5'($urandom_range(0, 3));
      d   = 5'($urandom_range(0, 3));
      if (rst) begin
        {e_stall, e_flush, e_f1, e_f2} = 6'b0;
      end else begin
        flushing = pc || (cyc <= flush_until);
        e_flush  = flushing;
        e_stall  = v && hist[0].ld && (hit(hist[0], s1) || hit(hist[0], s2)) && !flushing;
        e_f1     = hist[0].f1;
        e_f2     = hist[0].f2;
      end
      drive(rst, pc, v, rw, ld, s1, s2, d);
      n_checks++;
      if (o_stall !== e_stall) begin
        n_fail++; $display("FAIL rnd_stall @%0d: got %b want %b", n, o_stall, e_stall);
      end
      n_checks++;
      if (o_flush !== e_flush) begin
        n_fail++; $display("FAIL rnd_flush @%0d: got %b want %b", n, o_flush, e_flush);
      end
      n_checks++;
      if (o_fwd_rs1 !== e_f1) begin
        n_fail++; $display("FAIL rnd_fwd1 @%0d: got %b want %b", n, o_fwd_rs1, e_f1);
      end
      n_checks++;
      if (o_fwd_rs2 !== e_f2) begin
        n_fail++; $display("FAIL rnd_fwd2 @%0d: got %b want %b", n, o_fwd_rs2, e_f2);
      end
      if (rst) begin
        hist = '{bubble, bubble};
        flush_until = -1;
      end else begin
        nw = bubble;
        if (v && !e_stall && !e_flush)
          nw = '{valid: 1'b1, rd: d, rw: rw, ld: ld,
                 f1: pick(hist[0], hist[1], s1), f2: pick(hist[0], hist[1], s2)};
        if (pc) begin
          hist[0].valid = 1'b0;
          flush_until = cyc + FC - 1;
        end
        hist.push_front(nw);
        void'(hist.pop_back());
      end
      prev_rst = rst;
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0();
    test_redirect();
    test_loaduse_redirect();
    test_reset_in_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
